// File: rtl/mul_pkg.sv
// Shared encodings and sizing helpers for the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_ULO = 2'b00,
        MUL_SLO = 2'b01,
        MUL_UHI = 2'b10,
        MUL_SHI = 2'b11
    } mul_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter width for WIDTH/BITS_PER_CYCLE steps; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
        int unsigned n;
        n = width / bpc;
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic logic mode_signed(input mul_mode_e m);
        return (m == MUL_SLO) || (m == MUL_SHI);
    endfunction

    function automatic logic mode_high(input mul_mode_e m);
        return (m == MUL_UHI) || (m == MUL_SHI);
    endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// Request/response bundle between the CPU and the sequential multiplier.
interface seq_mul_unit_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    mul_mode_e            mode;
    logic [WIDTH-1:0]     data1;
    logic [WIDTH-1:0]     data2;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic [2*WIDTH-1:0]   product;
    logic                 zero;
    logic                 overflow;

    modport master (
        output start, mode, data1, data2,
        input  busy, done, result, product, zero, overflow
    );

    modport slave (
        input  start, mode, data1, data2,
        output busy, done, result, product, zero, overflow
    );
endinterface

// File: rtl/mul_partial_gen.sv
// Partial product of the multiplicand and one BITS_PER_CYCLE-wide multiplier chunk.
module mul_partial_gen #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                mcand,
    input  logic [BITS_PER_CYCLE-1:0]       chunk,
    output logic [WIDTH+BITS_PER_CYCLE-1:0] pp
);
    localparam int unsigned PW = WIDTH + BITS_PER_CYCLE;

    assign pp = PW'(mcand) * PW'(chunk);

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier: magnitudes are multiplied unsigned, sign is
// restored on the last RUN edge, then the selected half and flags are registered.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           reset,
    seq_mul_unit_if.slave  bus
);
    localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned PW = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned AW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic             accept, last;
    mul_mode_e        mode_q;
    logic [WIDTH-1:0] mcand_q, mplier_q;
    logic             neg_q;
    logic [AW-1:0]    acc_q, product_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q, zero_q, ovf_q;

    logic             in_signed;
    logic [WIDTH-1:0] mag1, mag2;
    logic [PW-1:0]    pp;
    logic [AW-1:0]    sum, fixed;
    logic [WIDTH-1:0] lo, hi, sel, sign_ext;
    logic             ovf_c;

    // Signed modes work on magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign in_signed = mode_signed(bus.mode);
    assign mag1 = (in_signed && bus.data1[WIDTH-1]) ? WIDTH'(~bus.data1 + WIDTH'(1)) : bus.data1;
    assign mag2 = (in_signed && bus.data2[WIDTH-1]) ? WIDTH'(~bus.data2 + WIDTH'(1)) : bus.data2;

    mul_partial_gen #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pgen (
        .mcand (mcand_q),
        .chunk (mplier_q[BITS_PER_CYCLE-1:0]),
        .pp    (pp)
    );

    assign sum      = acc_q + (AW'(pp) << (32'(cnt_q) * BITS_PER_CYCLE));
    assign fixed    = neg_q ? AW'(~sum + AW'(1)) : sum;
    assign lo       = fixed[WIDTH-1:0];
    assign hi       = fixed[AW-1:WIDTH];
    assign sel      = mode_high(mode_q) ? hi : lo;
    assign sign_ext = mode_signed(mode_q) ? {WIDTH{lo[WIDTH-1]}} : {WIDTH{1'b0}};
    assign ovf_c    = !mode_high(mode_q) && (hi != sign_ext);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, accumulation and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MUL_ULO;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mode_q   <= bus.mode;
                mcand_q  <= mag1;
                mplier_q <= mag2;
                neg_q    <= in_signed & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == S_RUN) begin
                acc_q    <= sum;
                cnt_q    <= cnt_q + CW'(1);
                mplier_q <= mplier_q >> BITS_PER_CYCLE;
                if (last) begin
                    product_q <= fixed;
                    result_q  <= sel;
                    zero_q    <= (sel == '0);
                    ovf_q     <= ovf_c;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (state_q == S_RUN) | (bus.start & (state_q != S_RUN));
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.product  = product_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/seq_mul_unit.md
# seq_mul_unit

Parametrised multi-cycle shift-add multiplier; successor to the single-cycle combinational 8-bit multiplier in the ALU. It supports configurable operand width, bits retired per cycle, signed/unsigned operands and low/high product selection. A START/BUSY/DONE handshake lets the CPU hold the PC through BUSYWAIT while a product is computed. It sits beside the ALU and drives the register-file write-back mux when a MUL-class opcode completes.

## Interface
- WIDTH, 8: operand width in bits; even, at least 4.
- BITS_PER_CYCLE, 1: multiplier bits retired per RUN cycle; must divide WIDTH.
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high; sampled on posedge CLK.
- START  in  1  request; sampled on posedge while state is IDLE or DONE.
- MODE  in  2  00 unsigned-low, 01 signed-low, 10 unsigned-high, 11 signed-high.
- DATA1  in  WIDTH  multiplicand.
- DATA2  in  WIDTH  multiplier.
- BUSY  out  1  combinational: (state==RUN) | (START & state!=RUN); feeds CPU BUSYWAIT.
- DONE  out  1  registered; high for exactly one cycle when the result becomes valid.
- RESULT  out  WIDTH  selected half of the product; held until the next accepted START.
- PRODUCT  out  2*WIDTH  full product, same hold rule.
- ZERO  out  1  RESULT == 0.
- OVERFLOW  out  1  low modes only: high half is not the zero/sign extension of the low half; always 0 in high modes.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE or DONE, START=1:**
  - Latch MODE.
  - Latch |DATA1| and |DATA2| as unsigned WIDTH-bit magnitudes. Take magnitudes only in signed modes; the most negative value maps to 2^(WIDTH-1).
  - Latch neg = DATA1[MSB]^DATA2[MSB] (signed modes, else 0).
  - Clear the accumulator (2*WIDTH bits) and the counter; go to RUN.
- **IDLE or DONE, START=0:** DONE goes to IDLE; IDLE stays IDLE.
- **RUN:** each edge adds the partial product of the next BITS_PER_CYCLE multiplier bits (LSB first) to the accumulator, shifted by counter*BITS_PER_CYCLE, then increments the counter.
- **Last RUN edge** (counter == N-1, N = WIDTH/BITS_PER_CYCLE):
  - Write PRODUCT = neg ? -(acc+pp) : (acc+pp), modulo 2^(2*WIDTH).
  - Write RESULT, ZERO and OVERFLOW from that value.
  - DONE<=1; go to DONE.
- **START while RUN:** ignored; no restart, no error.
- **Fixed latency:** a zero operand still takes N RUN cycles; there is no early termination.
- **RESET:** next edge, state=IDLE, accumulator, counter, PRODUCT, RESULT, DONE, ZERO and OVERFLOW all 0. BUSY=0 unless START=1. This holds mid-RUN and has priority over START.

## Timing
- Edge 0 accepts START. Edges 1..N are RUN. DONE is high during the cycle after edge N, so RESULT is valid N edges after acceptance.
- WIDTH=8, BITS_PER_CYCLE=1: N=8. WIDTH=8, BITS_PER_CYCLE=2: N=4.
- BUSY is high combinationally in the START cycle and through all RUN cycles, so the PC does not advance. BUSY is low in the DONE cycle, so write-back and PC advance coincide with DONE.
- Back-to-back: START in the DONE cycle is accepted. The old RESULT stays valid during that cycle, and the next DONE comes N edges later.
- Outputs change only on posedge CLK, except BUSY.

## Structure
- Shared package mul_pkg:
  - MODE encodings: MUL_ULO, MUL_SLO, MUL_UHI, MUL_SHI.
  - State encoding: S_IDLE, S_RUN, S_DONE.
  - Helper constant for the counter width, $clog2(WIDTH/BITS_PER_CYCLE).
- One sub-module, mul_partial_gen: combinational partial product of multiplicand × BITS_PER_CYCLE-bit chunk, WIDTH+BITS_PER_CYCLE bits wide.
- FSM, accumulator, sign fix-up and output registers live in seq_mul_unit.

## Test plan
- **Unsigned low:** MODE=00, 13×11 (WIDTH=8, BPC=1). Expect BUSY high for edges 0..8, DONE one cycle after edge 8, RESULT=0x8F, PRODUCT=0x008F, ZERO=0, OVERFLOW=0.
- **Signed:** MODE=01, 0xFD×0x05 (−3×5). Expect PRODUCT=0xFFF1, RESULT=0xF1, OVERFLOW=0. Repeat with MODE=11: RESULT=0xFF.
- **Overflow and zero flags:**
  - MODE=00, 0xFF×0xFF: PRODUCT=0xFE01, RESULT=0x01, OVERFLOW=1. MODE=10 gives RESULT=0xFE, OVERFLOW=0.
  - MODE=01, 0x80×0x80: PRODUCT=0x4000, RESULT=0x00, ZERO=1, OVERFLOW=1.
- **Reset mid-op and ignored START:**
  - Assert RESET at RUN edge 4. Next edge: all outputs 0, IDLE. A later START 7×6 gives 0x2A after 8 edges.
  - A START pulse during RUN does not change the result or the timing.
- **Back-to-back and BPC=2:**
  - START asserted in the DONE cycle: the second result appears exactly 8 edges later, and RESULT holds the first value during the DONE cycle.
  - With BITS_PER_CYCLE=2, 100×2 gives RESULT=0xC8 with DONE after edge 4.
